// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and helpers for the mux_arb_n block.
// Holds the channel-count limit and the select-width function used by the
// top-level multiplexer and its arbiter.
package mux_arb_pkg;

  // Largest channel count the block is designed for.
  localparam int MAX_CHANNELS = 16;

  // Width of a channel index. Never less than one bit.
  function automatic int sel_width(input int n);
    sel_width = (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// rr_arbiter: combinational arbiter.
// The search for a requester starts at index ptr and wraps from the top index
// back to 0. The first requester found wins. The winner is held internally as
// a one-hot vector and then encoded to an index.
// Tying ptr to 0 turns this into a fixed-priority arbiter where the lowest
// index wins.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  logic [CHANNELS-1:0] onehot;
  logic [SEL_W-1:0]    idx;

  // Walk the request vector starting at ptr and mark the first requester.
  always_comb begin
    onehot      = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx         = SEL_W'((int'(ptr) + k) % CHANNELS);
      onehot[idx] = onehot[idx] | (req[idx] & ~grant_valid);
      grant_valid = grant_valid | req[idx];
    end
  end

  // Encode the one-hot winner. At most one bit is set, so OR-ing the indices works.
  always_comb begin
    grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant = grant | (onehot[i] ? SEL_W'(i) : {SEL_W{1'b0}});
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N-way multiplexer with a valid/ready handshake on every
// channel.
// Each cycle one granted word moves into a single output register.
// Setting force_en bypasses arbitration: the channel given by force_sel is used.
// Optional feature: define MUX_ARB_ROUND_ROBIN_EN to get round-robin arbitration.
// When it is not defined, the arbiter uses fixed priority (lowest index wins)
// and there is no pointer register.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  // force_sel may address codes at or above CHANNELS. Padding the valid vector
  // makes those codes read as "not valid" instead of indexing out of range.
  localparam int PAD_N = 1 << SEL_W;

  logic             load_ok;
  logic             arb_valid;
  logic             grant_valid;
  logic             force_ok;
  logic [SEL_W-1:0] arb_grant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr;
  logic [PAD_N-1:0] valid_pad;
  logic [WIDTH-1:0] sel_data;

  // The output register can take a new word when it is empty or is being read this cycle.
  assign load_ok   = !out_valid || out_ready;
  assign valid_pad = PAD_N'(in_valid);
  assign force_ok  = (int'(force_sel) < CHANNELS) && valid_pad[force_sel];

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Choose between the forced grant and the arbiter's grant.
  always_comb begin
    if (force_en) begin
      grant       = force_sel;
      grant_valid = force_ok;
    end else begin
      grant       = arb_grant;
      grant_valid = arb_valid;
    end
  end

  // Select the granted channel's word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data |
                 ((grant == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
  end

  // Accept only the granted channel, only when the register can load, and never during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !reset && load_ok && grant_valid && (grant == SEL_W'(i));
    end
  end

  // Output register: load a granted word, or go empty once the current word has been read.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_ok) begin
      if (grant_valid) begin
        out_data  <= sel_data;
        out_sel   <= grant;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef MUX_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_next;

  assign ptr_next = (int'(arb_grant) == CHANNELS - 1) ? {SEL_W{1'b0}} : arb_grant + 1'b1;

  // The pointer moves to the channel after the winner, but only for arbitrated grants that are accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load_ok && !force_en && arb_valid) begin
      ptr <= ptr_next;
    end else begin
      ptr <= ptr;
    end
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed self-checking bench for mux_arb_n.
// It instantiates a 4-channel DUT and a 3-channel DUT. The 3-channel DUT is
// used to exercise an out-of-range force_sel.
module tb_mux_arb_n;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int N3  = 3;
  localparam int SW3 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            force_en;
  logic [SW-1:0]   force_sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_sel;

  logic            d3_reset;
  logic [N3*W-1:0] d3_in_data;
  logic [N3-1:0]   d3_in_valid;
  logic [N3-1:0]   d3_in_ready;
  logic            d3_force_en;
  logic [SW3-1:0]  d3_force_sel;
  logic [W-1:0]    d3_out_data;
  logic            d3_out_valid;
  logic            d3_out_ready;
  logic [SW3-1:0]  d3_out_sel;

  mux_arb_n #(.WIDTH(W), .CHANNELS(N)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel)
  );

  mux_arb_n #(.WIDTH(W), .CHANNELS(N3)) u_dut3 (
    .clk(clk), .reset(d3_reset), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .force_en(d3_force_en), .force_sel(d3_force_sel),
    .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_sel(d3_out_sel)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   rr    = 1'b0;
  int   fs[4] = '{2, 0, 1, 3};
  int   g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  // Expect channel ch to be accepted now and to show up in the output register after the next edge.
  task automatic xfer(input string tag, input int ch);
    exp_t e;
    e.data = in_data[ch*W +: W];
    e.sel  = SW'(ch);
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'(1) << ch);
    sb.push_back(e);
    tick();
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(e.data));
      chk({tag, "_sel"}, 32'(out_sel), 32'(e.sel));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
`ifdef MUX_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`endif
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; force_en = 1'b0; force_sel = 2'd0;
    set_data(16'h5000);
    d3_reset = 1'b1; d3_in_valid = 3'b111; d3_out_ready = 1'b1; d3_force_en = 1'b0;
    d3_force_sel = 2'd0; d3_in_data = {16'h7002, 16'h7001, 16'h7000};

    // Reset held for two edges with every channel valid.
    #2;
    chk("rst_ready_early", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0000);
    chk("rst_sel", 32'(out_sel), 32'd0);
    reset = 1'b0;

    // Forced mode: the chosen channel carries 0xBEEF.
    force_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_data(16'hA000);
      in_data[fs[k]*W +: W] = 16'hBEEF;
      force_sel = SW'(fs[k]);
      xfer("force", fs[k]);
    end

    // Arbitration with all channels valid. Forced grants left the pointer at 0.
    force_en = 1'b0;
    set_data(16'h1000);
    for (int k = 0; k < 5; k++) xfer("arb", rr ? (k % 4) : 0);

    // Sparse requests with the pointer at 1: the search wraps past 3 back to 0.
    in_valid = 4'b1001;
    set_data(16'h3000);
    xfer("wrap_a", rr ? 3 : 0);
    xfer("wrap_b", 0);

    // Backpressure: the held word is channel 0's 0x3000.
    in_valid = 4'b1111;
    set_data(16'h2000);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_data", 32'(out_data), 32'h3000);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    g = rr ? 1 : 0;
    xfer("bp_release", g);

    // Drain to empty: out_data and out_sel keep the last word.
    in_valid = 4'b0000;
    #1;
    chk("drain_ready", 32'(in_ready), 32'd0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data), 32'h2000 + 32'(g));
    chk("drain_sel", 32'(out_sel), 32'(g));

    // Reset arrives while a word is held: the word is discarded and nothing is accepted.
    in_valid = 4'b0001;
    xfer("pre_rst", 0);
    in_valid = 4'b1111;
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h0000);
    reset = 1'b0;

    // 3-channel DUT: forced select 2, then an out-of-range select of 3.
    d3_reset = 1'b0;
    d3_force_en = 1'b1;
    d3_force_sel = 2'd2;
    #1;
    chk("d3_f2_ready", 32'(d3_in_ready), 32'b100);
    tick();
    chk("d3_f2_valid", 32'(d3_out_valid), 32'd1);
    chk("d3_f2_data", 32'(d3_out_data), 32'h7002);
    chk("d3_f2_sel", 32'(d3_out_sel), 32'd2);
    d3_force_sel = 2'd3;
    #1;
    chk("d3_oor_ready", 32'(d3_in_ready), 32'd0);
    tick();
    chk("d3_oor_valid", 32'(d3_out_valid), 32'd0);
    chk("d3_oor_sel", 32'(d3_out_sel), 32'd2);
    chk("d3_oor_data", 32'(d3_out_data), 32'h7002);
    d3_force_en = 1'b0;
    #1;
    chk("d3_arb_ready", 32'(d3_in_ready), 32'b001);
    tick();
    chk("d3_arb_valid", 32'(d3_out_valid), 32'd1);
    chk("d3_arb_data", 32'(d3_out_data), 32'h7000);
    chk("d3_arb_sel", 32'(d3_out_sel), 32'd0);
    d3_reset = 1'b1;
    #1;
    chk("d3_rst_ready", 32'(d3_in_ready), 32'd0);
    tick();
    chk("d3_rst_valid", 32'(d3_out_valid), 32'd0);
    d3_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised, registered N-way multiplexer with valid/ready handshake on every channel. It arbitrates among CHANNELS input streams of WIDTH bits and forwards one word per cycle into a single output register. A forced-select mode reproduces plain sel-driven muxing. It sits between multiple word producers (register files, ALU result taps, I/O latches) and a single consumer in the Hack datapath.

## Interface
- WIDTH, 16, data bits per channel
- CHANNELS, 4, number of input channels; legal range 2..16
- SEL_W, $clog2(CHANNELS), width of select/index fields; derived, not overridden
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high; sampled on rising clk
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i has a word
- in_ready  output  CHANNELS  channel i word accepted this cycle (valid&&ready)
- force_en  input  1  1 = bypass arbitration, use force_sel
- force_sel  input  SEL_W  channel index used when force_en=1
- out_data  output  WIDTH  registered output word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts when out_valid&&out_ready
- out_sel  output  SEL_W  source channel of current out_data

## Operation
- Single output register stage (data, sel, valid).
- load_ok = !out_valid || out_ready (register empty or draining this cycle).
- Grant (combinational): force_en=1 -> grant force_sel if in_valid[force_sel] and force_sel<CHANNELS, else no grant; force_en=0 -> arbiter picks among in_valid.
- in_ready[i] = load_ok && grant_valid && grant==i; at most one bit set; never depends on in_valid[j], j≠i, except through arbitration.
- On grant with load_ok: out_data<=selected word, out_sel<=grant, out_valid<=1.
- On load_ok with no grant: out_valid<=0 only if it was draining; out_data/out_sel hold.
- out_valid&&!out_ready: register holds; all in_ready=0.
- Arbitrated grants advance priority pointer (see Configuration); forced grants never move the pointer.
- force_sel out of range (>=CHANNELS): no grant, no pointer change.
- Inputs may drop in_valid without handshake; no channel state is retained except the pointer.

## Timing
- Reset: out_valid=0, out_data=0, out_sel=0, pointer=0; in_ready=0 during reset cycle.
- Latency: input accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
- Throughput: one word/cycle with out_ready held 1.
- Backpressure: zero bubble; a drain and a new load occur on the same edge.
- Reset asserted mid-transfer: pending out word discarded, no in_ready asserted that cycle.
- force_en toggling: takes effect same cycle (combinational into grant).

## Configuration
- MUX_ARB_ROUND_ROBIN_EN defined: round-robin; after arbitrated grant to k, pointer<=(k+1) mod CHANNELS; search starts at pointer, wraps past CHANNELS-1 to 0.
- Not defined: fixed priority, lowest valid index wins; pointer register absent, always 0.

## Structure
- Shared package mux_arb_pkg: SEL_W clog2 function, CHANNELS limit constant (16).
- One sub-module: rr_arbiter (CHANNELS request vector + pointer -> grant index/valid, one-hot internally); fixed-priority path is rr_arbiter with pointer tied 0.
- Top holds output register, load_ok logic, force mux, pointer register.

## Test plan
- Reset: assert reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x0000, out_sel=0, in_ready=0000.
- Forced mode: force_en=1, force_sel=2, in_valid=1111, data c=0xBEEF, out_ready=1 -> in_ready=0100, next cycle out_data=0xBEEF, out_sel=2; repeat with sel=0,1,3.
- Round-robin (macro on): in_valid=1111 steady, out_ready=1 -> out_sel sequence 0,1,2,3,0; fixed priority (macro off) -> 0,0,0,0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data stable, in_ready=0000; release -> new word loaded same edge as drain, no bubble.
- Wrap/sparse: in_valid=1001, pointer=1 -> grant 3, then grant 0.
- Out-of-range/reset mid-op (CHANNELS=3): force_sel=3 -> no grant, out_valid falls after drain; reset with out_valid=1 -> out_valid=0 next edge.
